// File: rtl/aes_req_arbiter.sv
// Purpose  : round-robin share of one pipelined encryption_block between NUM_REQ requesters.
// Latency  : handshake at T -> response enters the FIFO at T+CORE_LATENCY+1, rsp_valid at T+CORE_LATENCY+2.
// Backpress: grants are withheld while in-flight jobs plus queued responses would exceed RSP_DEPTH.
//
// Ports:
//   clk, reset (async, active-low)     clock and reset
//   enable                             1: grant new jobs; 0: stop granting, drain in-flight work
//   req_valid/req_ready                per-requester handshake, req_ready is one-hot
//   req_key/req_data                   requester i fields at [i*N +: N]
//   core_key/core_plaintext            registered inputs to the encryption core
//   core_ciphertext                    core output, valid CORE_LATENCY cycles after the input register
//   rsp_valid/rsp_ready/rsp_id/rsp_data  response FIFO head (id = requester index)
//   busy                               controller is not idle
// Optional build: define AES_ARB_STATS_EN for stat_issued / stat_stall saturating counters.

module aes_req_arbiter #(
    parameter int  N            = 128,
    parameter int  NUM_REQ      = 2,
    parameter int  CORE_LATENCY = 11,
    parameter int  RSP_DEPTH    = 4,
    localparam int ID_W         = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic [NUM_REQ-1:0]   req_valid,
    output logic [NUM_REQ-1:0]   req_ready,
    input  logic [NUM_REQ*N-1:0] req_key,
    input  logic [NUM_REQ*N-1:0] req_data,
    output logic [N-1:0]         core_key,
    output logic [N-1:0]         core_plaintext,
    input  logic [N-1:0]         core_ciphertext,
    output logic                 rsp_valid,
    output logic [ID_W-1:0]      rsp_id,
    output logic [N-1:0]         rsp_data,
    input  logic                 rsp_ready,
    output logic                 busy
`ifdef AES_ARB_STATS_EN
    ,
    output logic [15:0]          stat_issued,
    output logic [15:0]          stat_stall
`endif
);

    localparam int CW = $clog2(RSP_DEPTH) + 1;

    typedef enum logic [1:0] {IDLE, ACTIVE, DRAIN} state_t;

    typedef struct packed {
        logic [ID_W-1:0] id;
        logic [N-1:0]    dat;
    } rsp_t;

    state_t                  state;
    logic [ID_W-1:0]         rr_ptr;
    logic [CW-1:0]           inflight;
    logic [CW-1:0]           fifo_cnt;
    logic [CW:0]             occupancy;
    logic                    credit_ok;
    logic                    drained;
    logic                    grant_vld;
    logic [ID_W-1:0]         grant_id;
    logic [CORE_LATENCY-1:0] tag_vld;
    logic [ID_W-1:0]         tag_id [CORE_LATENCY];
    rsp_t                    push_dat;
    rsp_t                    head_dat;

    // Jobs still inside the core count against the FIFO too, so a result
    // leaving the tag pipe always finds a free slot.
    assign occupancy = {1'b0, inflight} + {1'b0, fifo_cnt};
    assign credit_ok = occupancy < (CW+1)'(RSP_DEPTH);
    assign drained   = (inflight == '0) && (fifo_cnt == '0);
    assign busy      = (state != IDLE);

    // Scan starts one past the last winner; rr_ptr itself is checked last.
    // Gating on enable stops grants in the very cycle enable goes low.
    always_comb begin
        grant_vld = 1'b0;
        grant_id  = '0;
        if (state == ACTIVE && enable && credit_ok) begin
            for (int k = 1; k <= NUM_REQ; k++) begin
                if (!grant_vld && req_valid[(int'(rr_ptr) + k) % NUM_REQ]) begin
                    grant_vld = 1'b1;
                    grant_id  = ID_W'((int'(rr_ptr) + k) % NUM_REQ);
                end
            end
        end
        req_ready = '0;
        if (grant_vld) begin
            req_ready[grant_id] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE:    if (enable) state <= ACTIVE;
                ACTIVE:  if (!enable) state <= DRAIN;
                DRAIN: begin
                    if (enable) begin
                        state <= ACTIVE;
                    end else if (drained) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Core input registers, round-robin pointer and the tag pipe that
    // mirrors the core's depth so each ciphertext meets its requester id.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            core_key       <= '0;
            core_plaintext <= '0;
            rr_ptr         <= '0;
            inflight       <= '0;
            for (int s = 0; s < CORE_LATENCY; s++) begin
                tag_vld[s] <= 1'b0;
                tag_id[s]  <= '0;
            end
        end else begin
            if (grant_vld) begin
                core_key       <= req_key[int'(grant_id)*N +: N];
                core_plaintext <= req_data[int'(grant_id)*N +: N];
                rr_ptr         <= grant_id;
            end
            tag_vld[0] <= grant_vld;
            tag_id[0]  <= grant_id;
            for (int s = 1; s < CORE_LATENCY; s++) begin
                tag_vld[s] <= tag_vld[s-1];
                tag_id[s]  <= tag_id[s-1];
            end
            inflight <= inflight + CW'(grant_vld) - CW'(tag_vld[CORE_LATENCY-1]);
        end
    end

    assign push_dat = '{id: tag_id[CORE_LATENCY-1], dat: core_ciphertext};

    aes_arb_fifo #(
        .W     ($bits(rsp_t)),
        .DEPTH (RSP_DEPTH)
    ) u_rsp_fifo (
        .clk      (clk),
        .reset    (reset),
        .push_vld (tag_vld[CORE_LATENCY-1]),
        .push_dat (push_dat),
        .pop_rdy  (rsp_ready),
        .head_vld (rsp_valid),
        .head_dat (head_dat),
        .count    (fifo_cnt)
    );

    assign rsp_id   = head_dat.id;
    assign rsp_data = head_dat.dat;

`ifdef AES_ARB_STATS_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stat_issued <= '0;
            stat_stall  <= '0;
        end else begin
            if (grant_vld && stat_issued != 16'hFFFF) begin
                stat_issued <= stat_issued + 16'd1;
            end
            if (state == ACTIVE && (|req_valid) && !credit_ok && stat_stall != 16'hFFFF) begin
                stat_stall <= stat_stall + 16'd1;
            end
        end
    end
`endif

endmodule

// Purpose  : generic FIFO with a registered head entry.
// Latency  : push visible at the head two edges later when empty; back-to-back pops stream.
// Backpress: no full flag; the writer must guarantee count < DEPTH before pushing.
// count includes the head register, so it reflects everything the FIFO holds.
module aes_arb_fifo #(
    parameter int  W     = 8,
    parameter int  DEPTH = 4,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push_vld,
    input  logic [W-1:0]  push_dat,
    input  logic          pop_rdy,
    output logic          head_vld,
    output logic [W-1:0]  head_dat,
    output logic [CW-1:0] count
);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] mem_cnt;
    logic          head_take;
    logic          mem_rd;

    // Head reloads when empty or being popped this cycle.
    assign head_take = !head_vld || pop_rdy;
    assign mem_rd    = head_take && (mem_cnt != '0);
    assign count     = mem_cnt + CW'(head_vld);

    always_ff @(posedge clk) begin
        if (push_vld) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            mem_cnt  <= '0;
            head_vld <= 1'b0;
            head_dat <= '0;
        end else begin
            if (push_vld) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (mem_rd) begin
                rd_ptr   <= rd_ptr + AW'(1);
                head_dat <= mem[rd_ptr];
            end
            if (head_take) begin
                head_vld <= (mem_cnt != '0);
            end
            mem_cnt <= mem_cnt + CW'(push_vld) - CW'(mem_rd);
        end
    end

endmodule

// File: tb/tb_aes_req_arbiter.sv
// Purpose  : self-checking bench for aes_req_arbiter with a stand-in encryption core.
// Latency  : n/a (bench).
// Backpress: drives rsp_ready directly to create FIFO backpressure.
module tb_aes_req_arbiter;

    localparam int N   = 128;
    localparam int NR  = 2;
    localparam int L   = 11;
    localparam int D   = 4;
    localparam int IDW = 1;

    logic            clk = 1'b0;
    logic            reset;
    logic            enable;
    logic [NR-1:0]   req_valid;
    logic [NR-1:0]   req_ready;
    logic [NR*N-1:0] req_key;
    logic [NR*N-1:0] req_data;
    logic [N-1:0]    core_key;
    logic [N-1:0]    core_plaintext;
    logic [N-1:0]    core_ciphertext;
    logic            rsp_valid;
    logic [IDW-1:0]  rsp_id;
    logic [N-1:0]    rsp_data;
    logic            rsp_ready;
    logic            busy;
`ifdef AES_ARB_STATS_EN
    logic [15:0]     stat_issued;
    logic [15:0]     stat_stall;
`endif

    always #5 clk = ~clk;

    aes_req_arbiter #(.N(N), .NUM_REQ(NR), .CORE_LATENCY(L), .RSP_DEPTH(D)) dut (
        .clk             (clk),
        .reset           (reset),
        .enable          (enable),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_key         (req_key),
        .req_data        (req_data),
        .core_key        (core_key),
        .core_plaintext  (core_plaintext),
        .core_ciphertext (core_ciphertext),
        .rsp_valid       (rsp_valid),
        .rsp_id          (rsp_id),
        .rsp_data        (rsp_data),
        .rsp_ready       (rsp_ready),
        .busy            (busy)
`ifdef AES_ARB_STATS_EN
        ,
        .stat_issued     (stat_issued),
        .stat_stall      (stat_stall)
`endif
    );

    // Stand-in core: the FIPS-197 C.1 vector maps to its known ciphertext,
    // everything else to a cheap keyed scramble.
    function automatic logic [N-1:0] ref_cipher(input logic [N-1:0] k, input logic [N-1:0] p);
        logic [N-1:0] fk;
        logic [N-1:0] fp;
        fk = 128'h000102030405060708090a0b0c0d0e0f;
        fp = 128'h00112233445566778899aabbccddeeff;
        if (k == fk && p == fp) return 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
        return k ^ {p[63:0], p[127:64]} ^ 128'ha5a5a5a5_5a5a5a5a_c3c3c3c3_3c3c3c3c;
    endfunction

    // Ciphertext for the input register contents of cycle c appears in cycle c+L-1.
    logic [N-1:0] cpipe [L-1];
    always @(posedge clk) begin
        cpipe[0] <= ref_cipher(core_key, core_plaintext);
        for (int j = 1; j < L-1; j++) cpipe[j] <= cpipe[j-1];
    end
    assign core_ciphertext = cpipe[L-2];

    typedef struct {
        int           id;
        logic [N-1:0] dat;
    } exp_t;

    exp_t          sb[$];
    int            gseq[$];
    int            vectors = 0;
    int            miscompares = 0;
    int            cyc = 0;
    int            outstanding, issued, returned, rr_last, hs_cycle, rise_cycle;
    int            ret_per_id[NR];
    int            jobs_left[NR];
    logic [N-1:0]  key_r[NR];
    logic [N-1:0]  dat_r[NR];
    logic [NR-1:0] hs_vec;
    logic          rsp_valid_d;
    bit            rand_valid;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [N-1:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic int rr_pick(input logic [NR-1:0] v, input int last);
        for (int k = 1; k <= NR; k++) if (v[(last + k) % NR]) return (last + k) % NR;
        return -1;
    endfunction

    function automatic int jobs_total();
        int t = 0;
        for (int i = 0; i < NR; i++) t += jobs_left[i];
        return t;
    endfunction

    // Monitor: handshakes push expectations, pops compare against them.
    always @(negedge clk) begin
        if (reset) begin
            if (req_ready != '0)
                check("ready_onehot", 128'($countones(req_ready) == 1 && (req_ready & ~req_valid) == '0), 128'(1));
            hs_vec = req_valid & req_ready;
            if (hs_vec != '0) begin
                int id;
                id = 0;
                for (int i = 0; i < NR; i++) if (hs_vec[i]) id = i;
                check("rr_grant", 128'(id), 128'(rr_pick(req_valid, rr_last)));
                check("credit", 128'(outstanding < D), 128'(1));
                sb.push_back('{id, ref_cipher(key_r[id], dat_r[id])});
                outstanding++;
                issued++;
                rr_last  = id;
                hs_cycle = cyc;
                gseq.push_back(id);
            end
            if (rsp_valid && !rsp_valid_d) rise_cycle = cyc;
            rsp_valid_d = rsp_valid;
            if (rsp_valid && rsp_ready) begin
                if (sb.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_rsp: got id %0d data %h, expected no response", rsp_id, rsp_data);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("rsp_id", 128'(rsp_id), 128'(e.id));
                    check("rsp_data", rsp_data, e.dat);
                    outstanding--;
                    returned++;
                    ret_per_id[e.id]++;
                end
            end
        end else begin
            hs_vec      = '0;
            rsp_valid_d = 1'b0;
        end
    end

    // Requester driver: a requester holds its job until accepted.
    initial begin
        forever begin
            @(posedge clk);
            #2;
            for (int i = 0; i < NR; i++) begin
                if (hs_vec[i] && jobs_left[i] > 0) begin
                    jobs_left[i]--;
                    key_r[i] = rand128();
                    dat_r[i] = rand128();
                end
                req_valid[i]        = (jobs_left[i] > 0) && !(rand_valid && $urandom_range(0, 3) == 0);
                req_key[i*N +: N]  = key_r[i];
                req_data[i*N +: N] = dat_r[i];
            end
        end
    end

    task automatic cyc_wait(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_issued(input int target, input string name);
        int n = 0;
        while (n < 200 && issued < target) begin
            cyc_wait(1);
            n++;
        end
        check({name, "_issue_wait"}, 128'(issued), 128'(target));
    endtask

    task automatic wait_quiet(input int budget, input string name);
        int n = 0;
        while (n < budget && !(sb.size() == 0 && jobs_total() == 0 && !rsp_valid)) begin
            cyc_wait(1);
            n++;
        end
        vectors++;
        if (n >= budget) begin
            miscompares++;
            $display("FAIL %s_timeout: %0d responses pending after %0d cycles, expected 0", name, sb.size(), budget);
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #3 reset = 1'b0;
        for (int i = 0; i < NR; i++) jobs_left[i] = 0;
        @(negedge clk);
        check("rst_req_ready", 128'(req_ready), 128'(0));
        check("rst_rsp_valid", 128'(rsp_valid), 128'(0));
        check("rst_rsp_id", 128'(rsp_id), 128'(0));
        check("rst_rsp_data", rsp_data, 128'(0));
        check("rst_busy", 128'(busy), 128'(0));
        check("rst_core_key", core_key, 128'(0));
`ifdef AES_ARB_STATS_EN
        check("rst_stat_issued", 128'(stat_issued), 128'(0));
        check("rst_stat_stall", 128'(stat_stall), 128'(0));
`endif
        sb.delete();
        gseq.delete();
        outstanding = 0;
        issued      = 0;
        returned    = 0;
        rr_last     = 0;
        rise_cycle  = -1;
        for (int i = 0; i < NR; i++) ret_per_id[i] = 0;
        @(negedge clk);
        reset = 1'b1;
        cyc_wait(1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset      = 1'b0;
        enable     = 1'b0;
        rsp_ready  = 1'b0;
        rand_valid = 1'b0;
        req_valid  = '0;
        req_key    = '0;
        req_data   = '0;
        for (int i = 0; i < NR; i++) begin
            jobs_left[i] = 0;
            key_r[i]     = rand128();
            dat_r[i]     = rand128();
        end

        // 1: single FIPS job and its latency
        do_reset();
        enable    = 1'b1;
        rsp_ready = 1'b1;
        key_r[0]  = 128'h000102030405060708090a0b0c0d0e0f;
        dat_r[0]  = 128'h00112233445566778899aabbccddeeff;
        jobs_left[0] = 1;
        wait_quiet(100, "t1");
        check("t1_latency", 128'(rise_cycle - hs_cycle), 128'(L + 2));
        check("t1_returned", 128'(returned), 128'(1));

        // 2: fairness with both requesters always valid
        do_reset();
        enable       = 1'b1;
        rsp_ready    = 1'b1;
        jobs_left[0] = 4;
        jobs_left[1] = 4;
        wait_quiet(300, "t2");
        check("t2_grants", 128'(gseq.size()), 128'(8));
        for (int k = 0; k < 4 && k < gseq.size(); k++)
            check("t2_alternate", 128'(gseq[k]), 128'((k % 2 == 0) ? 1 : 0));
        check("t2_id0_count", 128'(ret_per_id[0]), 128'(4));
        check("t2_id1_count", 128'(ret_per_id[1]), 128'(4));

        // 3: backpressure limits acceptance to the FIFO depth
        do_reset();
        enable       = 1'b1;
        rsp_ready    = 1'b0;
        jobs_left[0] = 6;
        cyc_wait(40);
        check("t3_accepted", 128'(issued), 128'(D));
        check("t3_ready_low", 128'(req_ready), 128'(0));
`ifdef AES_ARB_STATS_EN
        check("t3_stat_stall_nonzero", 128'(stat_stall != 16'd0), 128'(1));
        check("t3_stat_issued", 128'(stat_issued), 128'(D));
`endif
        rsp_ready = 1'b1;
        wait_quiet(300, "t3");
        check("t3_returned", 128'(returned), 128'(6));

        // 4: drain after three jobs
        do_reset();
        enable       = 1'b1;
        rsp_ready    = 1'b1;
        jobs_left[0] = 5;
        wait_issued(3, "t4");
        enable = 1'b0;
        cyc_wait(3);
        check("t4_busy_draining", 128'(busy), 128'(1));
        cyc_wait(40);
        check("t4_no_new_grants", 128'(issued), 128'(3));
        check("t4_returned", 128'(returned), 128'(3));
        check("t4_idle", 128'(busy), 128'(0));
        jobs_left[0] = 0;
        cyc_wait(2);

        // 5: reset with two jobs in the pipe discards them
        do_reset();
        enable       = 1'b1;
        rsp_ready    = 1'b1;
        jobs_left[0] = 2;
        wait_issued(2, "t5");
        cyc_wait(3);
        do_reset();
        cyc_wait(30);
        check("t5_no_stale_rsp", 128'(returned), 128'(0));
        check("t5_no_rsp_valid", 128'(rise_cycle), 128'(-1));

        // 6: push and pop in the same cycle with three entries queued
        do_reset();
        enable       = 1'b1;
        rsp_ready    = 1'b0;
        jobs_left[0] = 3;
        cyc_wait(L + 10);
        jobs_left[0] = 1;
        wait_issued(4, "t6");
        begin
            int t;
            int n;
            t = hs_cycle;
            n = 0;
            while (cyc < t + L && n < 100) begin
                cyc_wait(1);
                n++;
            end
        end
        rsp_ready = 1'b1;
        cyc_wait(1);
        rsp_ready = 1'b0;
        check("t6_one_popped", 128'(returned), 128'(1));
        jobs_left[0] = 2;
        cyc_wait(20);
        check("t6_credit_after_pushpop", 128'(issued), 128'(5));
        rsp_ready = 1'b1;
        wait_quiet(300, "t6");
        check("t6_returned", 128'(returned), 128'(6));

        // 7: randomized valids, rsp_ready and enable toggling
        do_reset();
        enable       = 1'b1;
        rand_valid   = 1'b1;
        jobs_left[0] = 20;
        jobs_left[1] = 20;
        for (int c = 0; c < 400; c++) begin
            rsp_ready = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 15) == 0) enable = ~enable;
            cyc_wait(1);
        end
        rand_valid = 1'b0;
        enable     = 1'b1;
        rsp_ready  = 1'b1;
        wait_quiet(2000, "t7");
        check("t7_issued", 128'(issued), 128'(40));
        check("t7_returned", 128'(returned), 128'(40));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
